// File: rtl/pep_bsk_slot_tracker.sv
// rtl/pep_bsk_slot_tracker.sv - BSK cache slot tracker gating PBS batch starts on slot availability
module pep_bsk_slot_tracker #(
    parameter int SLOT_NB        = 4,
    parameter int PE_NB          = 2,
    parameter int IN_PIPE_DEPTH  = 2,
    parameter int OUT_PIPE_DEPTH = 1
) (
    input  logic                        clk,
    input  logic                        a_rst_n,
    input  logic                        inc_wr_ptr_in,
    input  logic                        req_vld,
    output logic                        req_rdy,
    input  logic [$clog2(PE_NB)-1:0]    req_pe_id,
    input  logic                        batch_done,
    input  logic                        flush,
    output logic                        flush_done,
    output logic [PE_NB-1:0]            batch_start_1h,
    output logic                        inc_rd_ptr,
    output logic [$clog2(SLOT_NB):0]    fill_cnt,
    output logic [1:0]                  error
);

    localparam int PW = $clog2(SLOT_NB) + 1;
    localparam int IW = $clog2(PE_NB);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_CLR,
        ST_WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          flush_active;
    logic          st_clr;
    logic          wr_evt;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] start_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] start_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW-1:0] filled;

    logic          wr_ok;
    logic          wr_ovf;
    logic          accept;
    logic          done_ok;
    logic          done_unf;
    logic [PE_NB-1:0] start_1h;
    logic [PE_NB:0]   out_stage_in;
    logic [PE_NB:0]   out_pipe [OUT_PIPE_DEPTH];

    // Flush sequencing: stop new starts, drain started batches, clear, then wait for flush release.
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        flush_active = 1'b1;
        flush_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                flush_active = 1'b0;
                if (flush) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (rd_ptr == start_ptr) begin
                    state_nxt = ST_CLR;
                end
            end
            ST_CLR: begin
                flush_done = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (!flush) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign st_clr = (state == ST_CLR);

    generate
        if (IN_PIPE_DEPTH == 0) begin : g_in_direct
            assign wr_evt = inc_wr_ptr_in;
        end else begin : g_in_pipe
            logic [IN_PIPE_DEPTH-1:0] in_pipe;

            always_ff @(posedge clk or negedge a_rst_n) begin
                if (!a_rst_n) begin
                    in_pipe <= '0;
                end else if (st_clr) begin
                    in_pipe <= '0;
                end else begin
                    in_pipe[0] <= inc_wr_ptr_in;
                    for (int i = 1; i < IN_PIPE_DEPTH; i++) begin
                        in_pipe[i] <= in_pipe[i-1];
                    end
                end
            end

            assign wr_evt = in_pipe[IN_PIPE_DEPTH-1];
        end
    endgenerate

    // All eligibility decisions look at the pre-update pointers only.
    assign filled   = wr_ptr - rd_ptr;
    assign req_rdy  = (wr_ptr != start_ptr) & ~flush_active;
    assign accept   = req_vld & req_rdy;
    assign wr_ovf   = wr_evt & ~st_clr & (filled == PW'(SLOT_NB));
    assign wr_ok    = wr_evt & ~st_clr & (filled != PW'(SLOT_NB));
    assign done_unf = batch_done & ~st_clr & (rd_ptr == start_ptr);
    assign done_ok  = batch_done & ~st_clr & (rd_ptr != start_ptr);

    assign wr_ptr_nxt    = wr_ptr + PW'(wr_ok);
    assign start_ptr_nxt = start_ptr + PW'(accept);
    assign rd_ptr_nxt    = rd_ptr + PW'(done_ok);

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            wr_ptr    <= '0;
            start_ptr <= '0;
            rd_ptr    <= '0;
            fill_cnt  <= '0;
            error     <= '0;
        end else if (st_clr) begin
            wr_ptr    <= '0;
            start_ptr <= '0;
            rd_ptr    <= '0;
            fill_cnt  <= '0;
            error     <= '0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            start_ptr <= start_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            fill_cnt  <= wr_ptr_nxt - rd_ptr_nxt;
            error     <= error | {done_unf, wr_ovf};
        end
    end

    // An out-of-range destination matches no bit, so the start pulse is all-zero.
    always_comb begin
        start_1h = '0;
        for (int i = 0; i < PE_NB; i++) begin
            start_1h[i] = accept & (req_pe_id == IW'(i));
        end
    end

    assign out_stage_in = {done_ok, start_1h};

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            for (int i = 0; i < OUT_PIPE_DEPTH; i++) begin
                out_pipe[i] <= '0;
            end
        end else begin
            out_pipe[0] <= out_stage_in;
            for (int i = 1; i < OUT_PIPE_DEPTH; i++) begin
                out_pipe[i] <= out_pipe[i-1];
            end
        end
    end

    assign inc_rd_ptr     = out_pipe[OUT_PIPE_DEPTH-1][PE_NB];
    assign batch_start_1h = out_pipe[OUT_PIPE_DEPTH-1][PE_NB-1:0];

endmodule

// File: tb/tb_pep_bsk_slot_tracker.sv
// tb/tb_pep_bsk_slot_tracker.sv - directed vector bench for pep_bsk_slot_tracker
module tb_pep_bsk_slot_tracker;

    logic       clk;
    logic       a_rst_n;
    logic       inc_wr_ptr_in;
    logic       req_vld;
    logic       req_rdy;
    logic [0:0] req_pe_id;
    logic       batch_done;
    logic       flush;
    logic       flush_done;
    logic [1:0] batch_start_1h;
    logic       inc_rd_ptr;
    logic [2:0] fill_cnt;
    logic [1:0] error;

    int checks;
    int errors;
    int ird_cnt;
    int acc_cnt;
    bit count_en;

    pep_bsk_slot_tracker #(
        .SLOT_NB(4),
        .PE_NB(2),
        .IN_PIPE_DEPTH(2),
        .OUT_PIPE_DEPTH(1)
    ) dut (
        .clk(clk),
        .a_rst_n(a_rst_n),
        .inc_wr_ptr_in(inc_wr_ptr_in),
        .req_vld(req_vld),
        .req_rdy(req_rdy),
        .req_pe_id(req_pe_id),
        .batch_done(batch_done),
        .flush(flush),
        .flush_done(flush_done),
        .batch_start_1h(batch_start_1h),
        .inc_rd_ptr(inc_rd_ptr),
        .fill_cnt(fill_cnt),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (count_en && inc_rd_ptr) begin
            ird_cnt++;
        end
    end

    typedef struct {
        logic       rst;
        logic       inc;
        logic       vld;
        logic       pe;
        logic       dn;
        logic       fl;
        logic       e_rdy;
        logic [2:0] e_fill;
        logic [1:0] e_bs;
        logic       e_ird;
        logic [1:0] e_err;
        logic       e_fd;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic rst, inc, vld, pe, dn, fl,
                                input logic rdy, input logic [2:0] fill, input logic [1:0] bs,
                                input logic ird, input logic [1:0] err, input logic fd);
        vec_t v;
        v.rst = rst; v.inc = inc; v.vld = vld; v.pe = pe; v.dn = dn; v.fl = fl;
        v.e_rdy = rdy; v.e_fill = fill; v.e_bs = bs; v.e_ird = ird; v.e_err = err; v.e_fd = fd;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        ird_cnt       = 0;
        acc_cnt       = 0;
        count_en      = 1'b0;
        a_rst_n       = 1'b0;
        inc_wr_ptr_in = 1'b0;
        req_vld       = 1'b0;
        req_pe_id     = 1'b0;
        batch_done    = 1'b0;
        flush         = 1'b0;

        //            rst inc vld pe dn fl | rdy fill bs ird err fd
        vecs.push_back(mk(0,1,1,1,0,0, 0,0,0,0,0,0));  // 0 reset state, first write pulse
        vecs.push_back(mk(0,0,1,1,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,1,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,1,0,0, 1,1,0,0,0,0));  // 3 ready, accept pe 1
        vecs.push_back(mk(0,0,0,0,0,0, 0,1,2,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0, 0,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,1,0, 0,0,0,0,0,0));  // 7 done underflow
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,2,0));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,2,0));  // 9 five writes
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,2,0));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,2,0));
        vecs.push_back(mk(0,1,0,0,0,0, 1,1,0,0,2,0));
        vecs.push_back(mk(0,1,0,0,0,0, 1,2,0,0,2,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,3,0,0,2,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,4,0,0,2,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,4,0,0,3,0));  // 16 overflow flagged, fill held
        vecs.push_back(mk(1,0,0,0,0,0, 1,4,0,0,3,0));  // 17 reset
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,0));  // 19 reset with pulse in pipe
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0,0));  // 23 build filled=2, one started
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0, 1,1,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0, 1,2,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,2,0,0,0,0));
        vecs.push_back(mk(0,0,1,1,1,0, 1,2,0,0,0,0));  // 29 write, accept and done together
        vecs.push_back(mk(0,1,0,0,0,0, 1,2,2,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 1,2,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0, 1,2,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 1,3,1,0,0,0));  // 33 flush with 2 started, 3 filled
        vecs.push_back(mk(0,0,0,0,0,1, 0,3,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,1, 0,3,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1, 0,2,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,1,1, 0,2,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,1, 0,1,0,1,0,0));  // 38 drained, extra done underflows
        vecs.push_back(mk(0,0,0,0,0,1, 0,1,0,0,2,1));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0));

        repeat (3) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            chk("req_rdy",        i, 8'(req_rdy),        8'(vecs[i].e_rdy));
            chk("fill_cnt",       i, 8'(fill_cnt),       8'(vecs[i].e_fill));
            chk("batch_start_1h", i, 8'(batch_start_1h), 8'(vecs[i].e_bs));
            chk("inc_rd_ptr",     i, 8'(inc_rd_ptr),     8'(vecs[i].e_ird));
            chk("error",          i, 8'(error),          8'(vecs[i].e_err));
            chk("flush_done",     i, 8'(flush_done),     8'(vecs[i].e_fd));
            a_rst_n       = ~vecs[i].rst;
            inc_wr_ptr_in = vecs[i].inc;
            req_vld       = vecs[i].vld;
            req_pe_id     = vecs[i].pe;
            batch_done    = vecs[i].dn;
            flush         = vecs[i].fl;
        end

        // Pointer wrap-around: repeated fill/start/done rounds.
        @(negedge clk);
        inc_wr_ptr_in = 1'b0;
        req_vld       = 1'b0;
        batch_done    = 1'b0;
        flush         = 1'b0;
        count_en      = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bit got;
            logic [1:0] exp_bs;
            got    = 1'b0;
            exp_bs = (k % 2 == 1) ? 2'b10 : 2'b01;
            inc_wr_ptr_in = 1'b1;
            @(negedge clk);
            inc_wr_ptr_in = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                @(negedge clk);
                got = req_rdy;
            end
            if (got) begin
                acc_cnt++;
                req_vld   = 1'b1;
                req_pe_id = exp_bs[1];
                @(negedge clk);
                req_vld = 1'b0;
                chk("wrap_start_1h", k, 8'(batch_start_1h), 8'(exp_bs));
                batch_done = 1'b1;
                @(negedge clk);
                batch_done = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        count_en = 1'b0;
        chk("wrap_accepts",  0, 8'(acc_cnt),  8'd20);
        chk("wrap_rd_pulses",0, 8'(ird_cnt),  8'd20);
        chk("wrap_fill_cnt", 0, 8'(fill_cnt), 8'd0);
        chk("wrap_error",    0, 8'(error),    8'd0);
        chk("wrap_req_rdy",  0, 8'(req_rdy),  8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
